// File: rtl/arbitro_pkg.sv
// Shared definitions for the multimode weighted round-robin arbiter:
// mode encodings and weight-field extraction from the packed weight bus.
package arbitro_pkg;

  typedef enum logic [1:0] {
    MODO_RR         = 2'd0,
    MODO_PESADO     = 2'd1,
    MODO_PRIO       = 2'd2,
    MODO_PESADO_ALT = 2'd3
  } modo_e;

  // Widest packed weight bus the extraction helper accepts.
  localparam int unsigned PESOS_MAX_BITS = 1024;

  // Returns field idx of width wbits (wbits < 32) from the packed weight bus.
  function automatic logic [31:0] extraer_peso(input logic [PESOS_MAX_BITS-1:0] pesos,
                                               input int unsigned idx,
                                               input int unsigned wbits);
    logic [PESOS_MAX_BITS-1:0] desplazado;
    logic [31:0]               mascara;
    desplazado = pesos >> (idx * wbits);
    mascara    = (32'd1 << wbits) - 32'd1;
    return desplazado[31:0] & mascara;
  endfunction

endpackage

// File: rtl/rr_buscador_rotativo.sv
// Combinational rotating-priority finder: first set request bit at or after
// start, wrapping modulo N.
module rr_buscador_rotativo #(
  parameter int unsigned N  = 4,
  parameter int unsigned SB = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SB-1:0] start,
  output logic [SB-1:0] idx_c,
  output logic          hallado_c
);

  always_comb begin
    logic [31:0] j;
    idx_c     = '0;
    hallado_c = 1'b0;
    j         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(start) + 32'(k)) % 32'(N);
      if (!hallado_c && req[j]) begin
        hallado_c = 1'b1;
        idx_c     = SB'(j);
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_pesado_multimodo.sv
// Queue arbiter with plain round-robin, weighted (deficit-style) round-robin
// and strict-priority modes; all outputs registered, one cycle of latency.
module arbitro_rr_pesado_multimodo
  import arbitro_pkg::*;
#(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned MAX_WEIGHT     = 64,
  parameter int unsigned WEIGHT_BITS    = $clog2(MAX_WEIGHT),
  parameter int unsigned SEL_BITS       = $clog2(QUEUE_QUANTITY)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [1:0]                          modo,
  input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] pesos,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  output logic [SEL_BITS-1:0]                 selector,
  output logic                                selector_enb,
  output logic [WEIGHT_BITS-1:0]              cuenta
);

  logic [WEIGHT_BITS-1:0]    peso [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] elegible;
  logic                      sin_mascara;
  logic [SEL_BITS-1:0]       start_rot;
  logic [SEL_BITS-1:0]       idx_rot, idx_prio;
  logic                      hallado_rot, hallado_prio;
  logic                      hay_elegible;

  assign sin_mascara  = (modo == MODO_RR) || (modo == MODO_PRIO);
  assign hay_elegible = hallado_rot | hallado_prio;

  // Weight 0 masks a queue only in the weighted modes.
  always_comb begin
    for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
      peso[i]     = WEIGHT_BITS'(extraer_peso(PESOS_MAX_BITS'(pesos), i, WEIGHT_BITS));
      elegible[i] = !buf_empty[i] && (sin_mascara || (peso[i] != '0));
    end
  end

  // Search starts past the current grant, or at the held selector when idle.
  always_comb begin
    start_rot = selector;
    if (selector_enb) begin
      if (32'(selector) == QUEUE_QUANTITY - 1) start_rot = '0;
      else                                     start_rot = selector + SEL_BITS'(1);
    end
  end

  rr_buscador_rotativo #(.N(QUEUE_QUANTITY), .SB(SEL_BITS)) u_busca_rot (
    .req       (elegible),
    .start     (start_rot),
    .idx_c     (idx_rot),
    .hallado_c (hallado_rot)
  );

  rr_buscador_rotativo #(.N(QUEUE_QUANTITY), .SB(SEL_BITS)) u_busca_prio (
    .req       (elegible),
    .start     ('0),
    .idx_c     (idx_prio),
    .hallado_c (hallado_prio)
  );

  // Priority: rst > enb=0 > no eligible > strict > continue burst > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      selector     <= '0;
      selector_enb <= 1'b0;
      cuenta       <= '0;
    end else if (!enb) begin
      selector_enb <= 1'b0;
    end else if (!hay_elegible) begin
      selector_enb <= 1'b0;
      cuenta       <= '0;
    end else if (modo == MODO_PRIO) begin
      selector     <= idx_prio;
      selector_enb <= 1'b1;
      cuenta       <= '0;
    end else if (selector_enb && elegible[selector] && (cuenta != '0)) begin
      selector_enb <= 1'b1;
      cuenta       <= cuenta - WEIGHT_BITS'(1);
    end else begin
      selector     <= idx_rot;
      selector_enb <= 1'b1;
      cuenta       <= (modo == MODO_RR) ? '0 : peso[idx_rot] - WEIGHT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_arbitro_rr_pesado_multimodo.sv
// Directed bench for the multimode arbiter with hand-computed grant sequences.
module tb_arbitro_rr_pesado_multimodo;

  localparam int unsigned QQ = 4;
  localparam int unsigned WB = 6;
  localparam int unsigned SB = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            enb;
  logic [1:0]      modo;
  logic [QQ*WB-1:0] pesos;
  logic [QQ-1:0]   buf_empty;
  logic [SB-1:0]   selector;
  logic            selector_enb;
  logic [WB-1:0]   cuenta;

  int checks = 0;
  int errors = 0;

  // Weighted start-up sequence with pesos q3..q0 = 6,3,2,1.
  int exp_sel_w [13] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 0};
  int exp_cta_w [13] = '{0, 1, 0, 2, 1, 0, 5, 4, 3, 2, 1, 0, 0};
  // Weighted sequence with q1 masked by weight 0, starting from q1 cuenta=1.
  int exp_sel_m [11] = '{2, 2, 2, 3, 3, 3, 3, 3, 3, 0, 2};
  int exp_cta_m [11] = '{2, 1, 0, 5, 4, 3, 2, 1, 0, 0, 2};

  arbitro_rr_pesado_multimodo #(
    .QUEUE_QUANTITY(QQ), .MAX_WEIGHT(64), .WEIGHT_BITS(WB), .SEL_BITS(SB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .modo         (modo),
    .pesos        (pesos),
    .buf_empty    (buf_empty),
    .selector     (selector),
    .selector_enb (selector_enb),
    .cuenta       (cuenta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string tag, input int s, input int e, input int c);
    tick();
    chk({tag, ".selector"}, int'(selector), s);
    chk({tag, ".selector_enb"}, int'(selector_enb), e);
    chk({tag, ".cuenta"}, int'(cuenta), c);
  endtask

  initial begin
    rst       = 1'b1;
    enb       = 1'b1;
    modo      = 2'd1;
    pesos     = {6'd6, 6'd3, 6'd2, 6'd1};
    buf_empty = 4'b0000;
    tick_chk("reset", 0, 0, 0);
    tick_chk("reset_hold", 0, 0, 0);

    // Weighted round-robin, period 12.
    rst = 1'b0;
    for (int i = 0; i < 13; i++) tick_chk($sformatf("pesado[%0d]", i), exp_sel_w[i], 1, exp_cta_w[i]);

    // Plain round-robin: one slot each, cuenta always 0.
    modo = 2'd0;
    for (int i = 0; i < 5; i++) tick_chk($sformatf("rr[%0d]", i), (i + 1) % 4, 1, 0);

    // q2 goes empty at its second grant: burst forfeited, q3 loaded.
    modo = 2'd1;
    tick_chk("q2_first", 2, 1, 2);
    tick_chk("q2_second", 2, 1, 1);
    buf_empty = 4'b0100;
    tick_chk("q2_forfeit", 3, 1, 5);
    buf_empty = 4'b0000;
    tick_chk("q3_cont", 3, 1, 4);

    // All queues empty: no grant, selector held; resumes at held selector.
    buf_empty = 4'b1111;
    tick_chk("vacio0", 3, 0, 0);
    tick_chk("vacio1", 3, 0, 0);
    buf_empty = 4'b0000;
    tick_chk("reanuda", 3, 1, 5);

    // Strict priority.
    modo      = 2'd2;
    buf_empty = 4'b0001;
    tick_chk("prio0", 1, 1, 0);
    tick_chk("prio1", 1, 1, 0);
    buf_empty = 4'b0000;
    tick_chk("prio_q0", 0, 1, 0);
    buf_empty = 4'b0001;
    tick_chk("prio_q1", 1, 1, 0);
    buf_empty = 4'b0000;

    // Leaving strict priority advances from selector+1.
    modo = 2'd3;
    tick_chk("sale_prio", 2, 1, 2);
    modo = 2'd1;
    tick_chk("q2_b", 2, 1, 1);
    tick_chk("q2_c", 2, 1, 0);
    tick_chk("q3_a", 3, 1, 5);
    tick_chk("q3_b", 3, 1, 4);
    tick_chk("q3_c", 3, 1, 3);
    tick_chk("q3_d", 3, 1, 2);
    tick_chk("q3_e", 3, 1, 1);
    tick_chk("q3_f", 3, 1, 0);
    tick_chk("q0_a", 0, 1, 0);
    tick_chk("q1_a", 1, 1, 1);

    // Weight 0 on q1 masks it; current q1 burst is abandoned.
    pesos = {6'd6, 6'd3, 6'd0, 6'd1};
    for (int i = 0; i < 11; i++) tick_chk($sformatf("mask[%0d]", i), exp_sel_m[i], 1, exp_cta_m[i]);

    // Reset in the middle of a q3 burst.
    tick_chk("pre_rst0", 2, 1, 1);
    tick_chk("pre_rst1", 2, 1, 0);
    tick_chk("pre_rst2", 3, 1, 5);
    rst = 1'b1;
    tick_chk("rst_burst", 0, 0, 0);
    rst = 1'b0;

    // Enable low holds selector and cuenta, drops the grant.
    tick_chk("post_rst", 0, 1, 0);
    tick_chk("q2_load", 2, 1, 2);
    enb = 1'b0;
    tick_chk("enb_off0", 2, 0, 2);
    tick_chk("enb_off1", 2, 0, 2);
    enb = 1'b1;
    tick_chk("enb_on", 2, 1, 2);

    // Reset wins over enb=0.
    enb = 1'b0;
    rst = 1'b1;
    tick_chk("rst_sobre_enb", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
